alu_driver: RTL and testbench

ALU_DRIVER -- requirements
Module: alu_driver

---
 rtl/alu_driver_if.sv | 54 +++++
 rtl/alu_driver.sv | 107 ++++++++++
 tb/tb_alu_driver.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_driver_if.sv
// Bundle of the command, register-load, ALU-side and response signals of
// alu_driver. The slave modport is the driver itself; master is whoever
// issues commands and owns the ALU.
//
// Handshakes: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both high. While valid is high, the offering
// side holds its payload stable until the transfer edge.
interface alu_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_opcode;
  logic [1:0] cmd_rd;
  logic [1:0] cmd_ra;
  logic [1:0] cmd_rb;
  logic       cmd_use_carry;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_fi;
  logic [6:0] alu_op;
  logic [7:0] alu_d;
  logic [7:0] alu_fo;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [2:0] flags;
  logic [1:0] dbg_state;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_rd, cmd_ra, cmd_rb, cmd_use_carry,
    input  wr_en, wr_addr, wr_data,
    input  alu_d, alu_fo,
    input  rsp_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_fi, alu_op,
    output rsp_valid, rsp_data, rsp_err,
    output flags, dbg_state
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_rd, cmd_ra, cmd_rb, cmd_use_carry,
    output wr_en, wr_addr, wr_data,
    output alu_d, alu_fo,
    output rsp_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_fi, alu_op,
    input  rsp_valid, rsp_data, rsp_err,
    input  flags, dbg_state
  );
endinterface

// File: rtl/alu_driver.sv
// Sequencer that feeds an external 8-bit ALU from a 4x8 register file.
// A command is accepted in IDLE, its operands are presented to the ALU for
// exactly one ISSUE cycle, the result is written back and stored flags are
// updated, and the response is held in RESP until it is taken.
module alu_driver (
  input  logic         clk,
  input  logic         rst_n,
  alu_driver_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] regs [4];
  logic [2:0] op_q;
  logic [1:0] rd_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic [7:0] alu_fi_q;
  logic [6:0] alu_op_q;
  logic       c_q;
  logic       z_q;
  logic       p_q;
  logic [7:0] rsp_data_q;
  logic       rsp_err_q;

  // The ALU-facing registers double as the latched operands: they are
  // loaded at accept and cleared when ISSUE ends, so they read zero in every
  // other state without any output gating.
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_fi    = alu_fi_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.flags     = {p_q, z_q, c_q};
  assign bus.dbg_state = state;

  // Control FSM, register file and flags. The external load is applied
  // before the writeback in program order so a same-index writeback wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
      op_q       <= 3'd0;
      rd_q       <= 2'd0;
      alu_a_q    <= 8'h00;
      alu_b_q    <= 8'h00;
      alu_fi_q   <= 8'h00;
      alu_op_q   <= 7'b0;
      c_q        <= 1'b0;
      z_q        <= 1'b0;
      p_q        <= 1'b0;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
    end else begin
      if (bus.wr_en) regs[bus.wr_addr] <= bus.wr_data;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_opcode == 3'd7) begin
              // Illegal opcode: answer straight away, touch nothing else.
              rsp_data_q <= 8'h00;
              rsp_err_q  <= 1'b1;
              state      <= RESP;
            end else begin
              op_q     <= bus.cmd_opcode;
              rd_q     <= bus.cmd_rd;
              alu_a_q  <= regs[bus.cmd_ra];
              alu_b_q  <= regs[bus.cmd_rb];
              alu_op_q <= 7'd1 << bus.cmd_opcode;
              // C cannot change before ISSUE ends, so sampling it here is
              // the same as sampling it during ISSUE.
              alu_fi_q <= {7'b0, bus.cmd_use_carry & c_q};
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          regs[rd_q] <= bus.alu_d;
          rsp_data_q <= bus.alu_d;
          rsp_err_q  <= 1'b0;
          z_q        <= bus.alu_fo[1];
          p_q        <= bus.alu_fo[2];
          // Only the arithmetic ops own the carry flag.
          if (op_q == 3'd0 || op_q == 3'd1) c_q <= bus.alu_fo[0];
          alu_a_q    <= 8'h00;
          alu_b_q    <= 8'h00;
          alu_fi_q   <= 8'h00;
          alu_op_q   <= 7'b0;
          state      <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver: a behavioural ALU answers the ISSUE cycle,
// and each command checks ISSUE-cycle outputs, response timing, payload and
// stored flags against hand-computed values.
module tb_alu_driver;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [7:0] exp_q[$];

  alu_driver_if bus ();

  alu_driver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- external ALU model ----------------
  logic [8:0] alu_s;
  logic [7:0] alu_res;
  logic       alu_cy;

  always_comb begin
    alu_s   = 9'd0;
    alu_res = 8'h00;
    alu_cy  = 1'b0;
    if (bus.alu_op[0]) begin
      alu_s   = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_fi[0]};
      alu_res = alu_s[7:0];
      alu_cy  = alu_s[8];
    end else if (bus.alu_op[1]) begin
      alu_s   = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {8'd0, bus.alu_fi[0]};
      alu_res = alu_s[7:0];
      alu_cy  = alu_s[8];
    end else if (bus.alu_op[2]) alu_res = bus.alu_a & bus.alu_b;
    else if (bus.alu_op[3]) alu_res = bus.alu_a | bus.alu_b;
    else if (bus.alu_op[4]) alu_res = ~bus.alu_a;
    else if (bus.alu_op[5]) alu_res = bus.alu_a << bus.alu_b;
    else if (bus.alu_op[6]) alu_res = bus.alu_a >> bus.alu_b;
  end

  assign bus.alu_d  = alu_res;
  assign bus.alu_fo = {5'b0, (!alu_res[7] && alu_res != 8'h00),
                       (alu_res == 8'h00), alu_cy};

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.cmd_valid     = 1'b0;
    bus.cmd_opcode    = 3'd0;
    bus.cmd_rd        = 2'd0;
    bus.cmd_ra        = 2'd0;
    bus.cmd_rb        = 2'd0;
    bus.cmd_use_carry = 1'b0;
    bus.wr_en         = 1'b0;
    bus.wr_addr       = 2'd0;
    bus.wr_data       = 8'h00;
    bus.rsp_ready     = 1'b0;
  endtask

  task automatic load_reg(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // wr_phase: 0 none, 1 external load in the accept cycle, 2 during ISSUE.
  task automatic run_cmd(input string tag, input logic [2:0] op,
                         input logic [1:0] rd, input logic [1:0] ra,
                         input logic [1:0] rb, input logic uc,
                         input logic [7:0] exp_a, input logic [7:0] exp_b,
                         input logic [7:0] exp_fi, input logic [7:0] exp_data,
                         input logic [2:0] exp_flags, input int stall,
                         input int wr_phase, input logic [1:0] wa,
                         input logic [7:0] wd);
    logic [7:0] exp_d;
    logic [6:0] one_hot;
    exp_q.push_back(exp_data);
    @(negedge clk);
    bus.cmd_valid     = 1'b1;
    bus.cmd_opcode    = op;
    bus.cmd_rd        = rd;
    bus.cmd_ra        = ra;
    bus.cmd_rb        = rb;
    bus.cmd_use_carry = uc;
    if (wr_phase == 1) begin
      bus.wr_en = 1'b1; bus.wr_addr = wa; bus.wr_data = wd;
    end
    chk({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.wr_en     = 1'b0;
    if (op != 3'd7) begin
      one_hot = 7'd1 << op;
      if (wr_phase == 2) begin
        bus.wr_en = 1'b1; bus.wr_addr = wa; bus.wr_data = wd;
      end
      chk({tag, " issue alu_op"}, 32'(bus.alu_op), 32'(one_hot));
      chk({tag, " issue alu_a"}, 32'(bus.alu_a), 32'(exp_a));
      chk({tag, " issue alu_b"}, 32'(bus.alu_b), 32'(exp_b));
      chk({tag, " issue alu_fi"}, 32'(bus.alu_fi), 32'(exp_fi));
      chk({tag, " issue rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      bus.wr_en = 1'b0;
    end else begin
      chk({tag, " illegal alu_op"}, 32'(bus.alu_op), 32'd0);
    end
    exp_d = exp_q.pop_front();
    chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, " rsp_data"}, 32'(bus.rsp_data), 32'(exp_d));
    chk({tag, " rsp_err"}, 32'(bus.rsp_err), (op == 3'd7) ? 32'd1 : 32'd0);
    chk({tag, " flags"}, 32'(bus.flags), 32'(exp_flags));
    chk({tag, " resp alu_op"}, 32'(bus.alu_op), 32'd0);
    for (int i = 0; i < stall; i++) begin
      bus.cmd_valid  = 1'b1;
      bus.cmd_opcode = 3'd0;
      bus.cmd_rd     = 2'd3;
      @(negedge clk);
      chk({tag, " stall rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, " stall rsp_data"}, 32'(bus.rsp_data), 32'(exp_d));
      chk({tag, " stall cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, " done rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, " done cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset flags", 32'(bus.flags), 32'd0);
    chk("reset alu_op", 32'(bus.alu_op), 32'd0);
    chk("reset state", 32'(bus.dbg_state), 32'd0);
    chk("reset cmd_ready after", 32'(bus.cmd_ready), 32'd1);

    load_reg(2'd0, 8'hF0);
    load_reg(2'd1, 8'h20);
    //       tag        op    rd    ra    rb    uc  a      b      fi     data   flags   st w  wa    wd
    run_cmd("add",      3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 8'hF0, 8'h20, 8'h00, 8'h10, 3'b101, 0, 0, 2'd0, 8'h00);
    run_cmd("adc",      3'd0, 2'd3, 2'd0, 2'd1, 1'b1, 8'hF0, 8'h20, 8'h01, 8'h11, 3'b101, 0, 0, 2'd0, 8'h00);
    run_cmd("sub_zero", 3'd1, 2'd0, 2'd0, 2'd0, 1'b0, 8'hF0, 8'hF0, 8'h00, 8'h00, 3'b010, 0, 0, 2'd0, 8'h00);
    run_cmd("or_r2r3",  3'd3, 2'd2, 2'd2, 2'd3, 1'b0, 8'h10, 8'h11, 8'h00, 8'h11, 3'b100, 0, 0, 2'd0, 8'h00);
    load_reg(2'd1, 8'h01);
    load_reg(2'd2, 8'hFF);
    run_cmd("add_wrap", 3'd0, 2'd2, 2'd2, 2'd1, 1'b0, 8'hFF, 8'h01, 8'h00, 8'h00, 3'b011, 0, 0, 2'd0, 8'h00);
    run_cmd("not",      3'd4, 2'd1, 2'd1, 2'd0, 1'b0, 8'h01, 8'h00, 8'h00, 8'hFE, 3'b001, 0, 0, 2'd0, 8'h00);
    load_reg(2'd0, 8'h01);
    load_reg(2'd3, 8'h03);
    run_cmd("shl",      3'd5, 2'd2, 2'd0, 2'd3, 1'b0, 8'h01, 8'h03, 8'h00, 8'h08, 3'b101, 0, 0, 2'd0, 8'h00);
    run_cmd("illegal",  3'd7, 2'd1, 2'd0, 2'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 3'b101, 0, 0, 2'd0, 8'h00);
    // r1 still 0xFE after the illegal command; external load to rd during ISSUE loses.
    run_cmd("or_stall", 3'd3, 2'd0, 2'd2, 2'd1, 1'b0, 8'h08, 8'hFE, 8'h00, 8'hFE, 3'b001, 5, 2, 2'd0, 8'h55);
    // Accept-cycle load of r0 must not be forwarded; r0 holds the 0xFE writeback.
    run_cmd("and_nofwd",3'd2, 2'd3, 2'd0, 2'd2, 1'b0, 8'hFE, 8'h08, 8'h00, 8'h08, 3'b101, 0, 1, 2'd0, 8'hAA);
    load_reg(2'd3, 8'h02);
    run_cmd("shr",      3'd6, 2'd1, 2'd0, 2'd3, 1'b0, 8'hAA, 8'h02, 8'h00, 8'h2A, 3'b101, 0, 0, 2'd0, 8'h00);
    run_cmd("sbc",      3'd1, 2'd2, 2'd0, 2'd3, 1'b1, 8'hAA, 8'h02, 8'h01, 8'hA7, 3'b000, 0, 0, 2'd0, 8'h00);

    // Reset pulsed while a response is pending.
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = 3'd0;
    bus.cmd_rd     = 2'd0;
    bus.cmd_ra     = 2'd0;
    bus.cmd_rb     = 2'd1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_resp rsp_valid before", 32'(bus.rsp_valid), 32'd1);
    #2;
    rst_n       = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'd0;
    bus.wr_data = 8'h77;
    #1;
    chk("rst_resp rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_resp cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_resp flags", 32'(bus.flags), 32'd0);
    chk("rst_resp rsp_data", 32'(bus.rsp_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    bus.wr_en = 1'b0;
    chk("rst_resp cmd_ready after", 32'(bus.cmd_ready), 32'd1);
    run_cmd("post_rst", 3'd3, 2'd0, 2'd0, 2'd1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b010, 0, 0, 2'd0, 8'h00);
    run_cmd("post_rst2",3'd3, 2'd1, 2'd2, 2'd3, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b010, 0, 0, 2'd0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
